alu_seq_divider: RTL and testbench
==================================

# alu_seq_divider

Multi-cycle signed integer divide/modulo unit for the Execute stage, used next to the combinational ALU for the division (sel 4'b0011) and modulo (sel 4'b0100) operations. It accepts one operand pair through a valid/ready handshake and computes the quotient or remainder with a restoring shift-subtract loop, one bit per cycle. It returns the result with the same C/Z/V/N flag semantics as the ALU. Execute stalls on in_ready/out_valid instead of timing a long combinational divider path.

## Interface
- WIDTH, 4, operand/result width in bits (two's complement); WIDTH >= 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair and op are valid
- in_ready  out  1  unit can accept; high exactly when state is IDLE
- A  in  WIDTH  dividend
- B  in  WIDTH  divisor
- op  in  1  0 = quotient (ALU sel 4'b0011), 1 = remainder (ALU sel 4'b0100)
- out_valid  out  1  Out and flags valid
- out_ready  in  1  consumer takes the result
- Out  out  WIDTH  quotient or remainder
- C, N, Z, V  out  1 each  carry, negative, zero, overflow flags

## Operation
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE: in_ready=1. If in_valid is high at the edge, capture A, B and op, then go to SETUP. Operand changes after the accept edge have no effect.
- SETUP: register |A| and |B|, the sign of the quotient (A[MSB]^B[MSB]) and the sign of the remainder (A[MSB]). Detect the special cases (B==0; A==MIN and B==-1). Clear the partial remainder and the bit counter. Go to ITER.
- ITER: one restoring step per cycle: shift the {rem, quo} pair left, trial-subtract |B|, set the quotient bit if the result is non-negative. The counter counts 0..WIDTH-1. Go to FIXUP after WIDTH steps.
- FIXUP: apply signs and special cases, select by op, compute flags, register Out/flags. Go to DONE.
- DONE: out_valid=1, Out/flags held stable. On out_ready at the edge, go to IDLE.
- Arithmetic: the quotient truncates toward zero. The remainder has the sign of the dividend and |rem| < |B|. A = q*B + r holds whenever B != 0 and there is no overflow. Absolute values use WIDTH+1 bits internally so that |MIN| is representable.
- Special case A==MIN, B==-1: quotient Out=MIN, V=1; remainder Out=0, V=0.
- Special case B==0: quotient Out=all ones, V=1; remainder Out=A, V=1.
- Flags: C=0 always; Z=(Out==0); N=Out[WIDTH-1]; V=0 except in the special cases above.
- Special cases still pass through ITER, so latency does not depend on the data.

## Timing
- Latency is fixed. With the accept edge as edge 0, out_valid rises after edge WIDTH+2 (6 edges for WIDTH=4).
- out_valid stays high, and Out/flags stay stable, until the first edge where out_ready=1. The state returns to IDLE on that edge.
- in_ready rises the cycle after the result is taken. There is no overlap: the minimum spacing between accepts is WIDTH+4 edges.
- in_valid is ignored in every state except IDLE. out_ready is ignored in every state except DONE.
- out_valid is registered (a state decode of DONE). in_ready is a state decode of IDLE.
- Reset values (asserted asynchronously): state=IDLE, in_ready=1, out_valid=0, Out=0, C=N=Z=V=0, counter=0.
- Reset asserted mid-operation aborts the operation, with no result produced. The first accept after reset is possible on the first edge after rst deasserts.

## Test plan
- Reset then idle: after rst low then high, in_ready=1, out_valid=0, Out=0000, all flags 0. Asserting rst during ITER returns the unit to IDLE, and no out_valid pulse is produced.
- Quotient, WIDTH=4, out_ready held high:
  - A=0011, B=0101 -> Out=0000, Z=1, N=0, V=0.
  - A=0011, B=1111 -> Out=1101, N=1.
  - A=1101, B=0111 -> Out=0000, Z=1.
  - In each case out_valid rises exactly 6 edges after the accept.
- Remainder, op=1:
  - 0000 % 1100 -> 0000, Z=1.
  - 0011 % 0010 -> 0001.
  - 0100 % 1000 -> 0100.
  - 0111 % 0110 -> 0001.
  - 1101 % 1010 -> 1101, N=1.
  - C=0 in every case.
- Overflow and divide-by-zero:
  - A=1000, B=1111, op=0 -> Out=1000, V=1, N=1.
  - Same operands with op=1 -> Out=0000, V=0, Z=1.
  - B=0000, A=0101 -> op=0 gives Out=1111, V=1; op=1 gives Out=0101, V=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Out/flags stay stable and in_ready=0, while in_valid pulses with new operands are ignored. Then raise out_ready for one edge: the unit goes to IDLE, and the next accept produces the correct new result.
- Randomized sweep: 200 random A/B/op with random in_valid/out_ready gaps. Check against a reference model of truncating signed div/mod plus the special cases, and check the exact latency of 6 edges.

Source files
------------

// File: rtl/alu_seq_divider.sv
// Purpose : multi-cycle signed divide / modulo next to the combinational ALU; restoring loop, one bit per cycle.
// Latency : fixed WIDTH+2 edges from the accept edge to out_valid, independent of operand values.
// Backpres: the result is held in DONE until out_ready; in_ready is high only in IDLE, so there is no overlap.
// Ports   : clk/rst (async active-low); in_valid/in_ready + A, B, op (0=quotient, 1=remainder);
//           out_valid/out_ready + Out and flags C, N, Z, V.
module alu_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             C,
    output logic             N,
    output logic             Z,
    output logic             V
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic [WIDTH:0]   r_abs_b;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div0;
    logic             r_ovf;
    logic [WIDTH-1:0] r_out;
    logic             r_n;
    logic             r_z;
    logic             r_v;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_abs_b;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_val;
    logic [WIDTH-1:0] w_r_val;
    logic [WIDTH-1:0] w_res;
    logic             w_vf;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Out       = r_out;
    assign C         = 1'b0;
    assign N         = r_n;
    assign Z         = r_z;
    assign V         = r_v;

    // The dividend magnitude is kept as an unsigned WIDTH-bit value: |MIN| = 2^(WIDTH-1)
    // still fits unsigned. The divisor magnitude gets the extra bit for the trial subtract.
    assign w_abs_a = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
    assign w_b_ext = {r_b[WIDTH-1], r_b};
    assign w_abs_b = r_b[WIDTH-1] ? (~w_b_ext + 1'b1) : w_b_ext;

    // Restoring step: shift the next dividend bit into the partial remainder and try |B|.
    // The top bit of w_diff is the borrow; no borrow means the quotient bit is 1.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_abs_b};
    assign w_ge    = ~w_diff[WIDTH+1];

    assign w_q_val = r_q_neg ? (~r_quo + 1'b1) : r_quo;
    assign w_r_val = r_r_neg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    always_comb begin
        w_res = r_op ? w_r_val : w_q_val;
        w_vf  = 1'b0;
        if (r_div0) begin
            w_res = r_op ? r_a : {WIDTH{1'b1}};
            w_vf  = 1'b1;
        end else if (r_ovf) begin
            // MIN / -1 overflows the quotient; the remainder is exactly zero.
            w_res = r_op ? {WIDTH{1'b0}} : MIN_VAL;
            w_vf  = ~r_op;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = SETUP;
            SETUP:   w_next = ITER;
            ITER:    if (r_cnt == CW'(WIDTH-1)) w_next = FIXUP;
            FIXUP:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_abs_b <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
            r_out   <= '0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a  <= A;
                        r_b  <= B;
                        r_op <= op;
                    end
                end
                SETUP: begin
                    r_quo   <= w_abs_a;
                    r_abs_b <= w_abs_b;
                    r_q_neg <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_r_neg <= r_a[WIDTH-1];
                    r_div0  <= (r_b == '0);
                    r_ovf   <= (r_a == MIN_VAL) && (r_b == {WIDTH{1'b1}});
                    r_rem   <= '0;
                    r_cnt   <= '0;
                end
                ITER: begin
                    r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIXUP: begin
                    r_out <= w_res;
                    r_z   <= (w_res == '0);
                    r_n   <= w_res[WIDTH-1];
                    r_v   <= w_vf;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
module tb_alu_seq_divider;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Out;
    logic       C, N, Z, V;

    alu_seq_divider #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .C(C), .N(N), .Z(Z), .V(V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] out;
        logic       c, n, z, v;
        int         acc;
    } exp_t;

    typedef struct {
        logic [3:0] a, b;
        logic       op;
        logic [3:0] out;
        logic       n, z, v;
        int         hold;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    bit   prev_ov = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic monitor();
        if (rst) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    cur = sb.pop_front();
                    chk("latency", cyc - cur.acc, 6);
                    chk("Out", Out, cur.out);
                    chk("C", C, cur.c);
                    chk("N", N, cur.n);
                    chk("Z", Z, cur.z);
                    chk("V", V, cur.v);
                    chk("in_ready_in_done", in_ready, 0);
                end
            end else if (out_valid) begin
                chk("held_Out", Out, cur.out);
                chk("held_flags", {C, N, Z, V}, {cur.c, cur.n, cur.z, cur.v});
                chk("held_in_ready", in_ready, 0);
            end
        end
        prev_ov = out_valid;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic o);
        exp_t e;
        int   sa, sbv, q, r;
        sa  = $signed(a);
        sbv = $signed(b);
        e.c = 1'b0;
        e.acc = 0;
        if (b == 4'h0) begin
            e.out = o ? a : 4'hF;
            e.v   = 1'b1;
        end else if (a == 4'h8 && b == 4'hF) begin
            e.out = o ? 4'h0 : 4'h8;
            e.v   = !o;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            e.out = o ? r[3:0] : q[3:0];
            e.v   = 1'b0;
        end
        e.z = (e.out == 4'h0);
        e.n = e.out[3];
        return e;
    endfunction

    // One complete transaction: optional idle gap, accept, busy period with junk on the
    // input side, 'hold' cycles of backpressure in DONE, then the handshake.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic o,
                         input exp_t e, input int hold, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) step();
        t = 0;
        while (!in_ready && t < 40) begin step(); t++; end
        if (!in_ready) begin
            fail_now("accept_timeout");
            return;
        end
        A = a; B = b; op = o; in_valid = 1'b1;
        e.acc = cyc + 1;
        sb.push_back(e);
        step();
        t = 0;
        while (!out_valid && t < 40) begin
            in_valid  = 1'($urandom_range(0, 1));
            A         = 4'($urandom_range(0, 15));
            B         = 4'($urandom_range(0, 15));
            op        = 1'($urandom_range(0, 1));
            out_ready = (hold == 0);
            step();
            t++;
        end
        if (!out_valid) begin
            fail_now("result_timeout");
            sb.delete();
            return;
        end
        repeat (hold) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            A         = 4'($urandom_range(0, 15));
            B         = 4'($urandom_range(0, 15));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after_take", in_ready, 1);
        chk("out_valid_after_take", out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0] ra, rb;
        logic       ro;

        //            a      b      op    out    n     z     v     hold
        tbl[0]  = '{4'h3, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{4'h3, 4'hF, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{4'hD, 4'h7, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 0};
        tbl[3]  = '{4'h0, 4'hC, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 0};
        tbl[4]  = '{4'h3, 4'h2, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{4'h4, 4'h8, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{4'h7, 4'h6, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{4'hD, 4'hA, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0, 0};
        tbl[8]  = '{4'h8, 4'hF, 1'b0, 4'h8, 1'b1, 1'b0, 1'b1, 0};
        tbl[9]  = '{4'h8, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 0};
        tbl[10] = '{4'h5, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 0};
        tbl[11] = '{4'h5, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 5};
        tbl[12] = '{4'h6, 4'hE, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 4'h0; B = 4'h0; op = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Out", Out, 0);
        chk("rst_flags", {C, N, Z, V}, 0);
        rst = 1'b1;
        step();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_Out", Out, 0);
        chk("idle_flags", {C, N, Z, V}, 0);

        for (int i = 0; i < 13; i++) begin
            e.out = tbl[i].out; e.c = 1'b0; e.n = tbl[i].n;
            e.z = tbl[i].z; e.v = tbl[i].v; e.acc = 0;
            do_op(tbl[i].a, tbl[i].b, tbl[i].op, e, tbl[i].hold, i % 2);
        end

        // Reset in the middle of the iteration loop: no result may appear.
        A = 4'h7; B = 4'h2; op = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        step();
        rst = 1'b1;
        repeat (12) step();
        chk("after_midrst_out_valid", out_valid, 0);
        chk("after_midrst_in_ready", in_ready, 1);

        // Accept on the first edge after reset release.
        rst = 1'b0;
        step();
        rst = 1'b1;
        do_op(4'h9, 4'h3, 1'b1, model(4'h9, 4'h3, 1'b1), 0, 0);

        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ro = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = 4'h0;
                1: begin ra = 4'h8; rb = 4'hF; end
                default: ;
            endcase
            do_op(ra, rb, ro, model(ra, rb, ro), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
